// File: rtl/dual_core_mem_arbiter.sv
// Shares one RAM port between the dcache and icache of two cores. Data traffic
// beats instruction traffic, cores round-robin, and dcache block pairs stay locked.
module dual_core_mem_arbiter #(
    parameter int LOCK_TIMEOUT = 8,
    parameter int ADDR_W       = 32
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [1:0]             dREN,
    input  logic [1:0]             dWEN,
    input  logic [1:0][ADDR_W-1:0] daddr,
    input  logic [1:0][ADDR_W-1:0] dstore,
    input  logic [1:0]             iREN,
    input  logic [1:0][ADDR_W-1:0] iaddr,
    output logic [1:0]             dwait,
    output logic [1:0]             iwait,
    output logic [1:0][ADDR_W-1:0] dload,
    output logic [1:0][ADDR_W-1:0] iload,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [ADDR_W-1:0]      ramaddr,
    output logic [ADDR_W-1:0]      ramstore,
    input  logic [ADDR_W-1:0]      ramload,
    input  logic [1:0]             ramstate
);

    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [1:0] {IDLE, ACCESS, LOCKED} state_t;

    state_t           state;
    logic             grant_d;
    logic             grant_core;
    logic             dptr;
    logic             iptr;
    logic [CNT_W-1:0] lock_cnt;

    logic [1:0] d_active;
    logic [1:0] i_active;
    logic       any_req;
    logic       win_d;
    logic       win_core;
    logic       grant_active;
    logic       completing;

    always_comb begin
        d_active     = dREN | dWEN;
        i_active     = iREN;
        any_req      = (|d_active) | (|i_active);
        win_d        = |d_active;
        win_core     = 1'b0;
        if (win_d) begin
            win_core = d_active[dptr] ? dptr : ~dptr;
        end else begin
            win_core = i_active[iptr] ? iptr : ~iptr;
        end
        grant_active = grant_d ? d_active[grant_core] : i_active[grant_core];
        completing   = (state == ACCESS) && grant_active && (ramstate == RAM_ACCESS);
    end

    // RAM side follows the granted requester's live inputs so an abandon drops enables at once
    always_comb begin
        dwait    = 2'b11;
        iwait    = 2'b11;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (state == ACCESS) begin
            if (grant_d) begin
                ramaddr  = daddr[grant_core];
                ramstore = dstore[grant_core];
                ramWEN   = dWEN[grant_core];
                ramREN   = dREN[grant_core] & ~dWEN[grant_core];
            end else begin
                ramaddr  = iaddr[grant_core];
                ramREN   = iREN[grant_core];
            end
            if (completing) begin
                if (grant_d) begin
                    dwait[grant_core] = 1'b0;
                end else begin
                    iwait[grant_core] = 1'b0;
                end
            end
        end
    end

    assign dload[0] = ramload;
    assign dload[1] = ramload;
    assign iload[0] = ramload;
    assign iload[1] = ramload;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            grant_d    <= 1'b0;
            grant_core <= 1'b0;
            dptr       <= 1'b0;
            iptr       <= 1'b0;
            lock_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_d    <= win_d;
                        grant_core <= win_core;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!grant_active) begin
                        state <= IDLE;
                    end else if (ramstate == RAM_ACCESS) begin
                        // The even word of a dcache block keeps the grant for its odd partner
                        if (grant_d && !daddr[grant_core][2]) begin
                            state <= LOCKED;
                        end else begin
                            if (grant_d) begin
                                dptr <= ~dptr;
                            end else begin
                                iptr <= ~iptr;
                            end
                            state <= IDLE;
                        end
                    end
                end
                LOCKED: begin
                    if (grant_active) begin
                        lock_cnt <= '0;
                        state    <= ACCESS;
                    end else if (lock_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        lock_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
